// File: rtl/pattern_sched_pkg.sv
// Shared types and constants for the pattern scheduler: FSM state encoding,
// requester count, pattern width, idle owner code and the round-robin picker.
package pattern_sched_pkg;

    localparam int          NUM_REQ = 3;
    localparam int          PAT_W   = 12;
    localparam int          BIT_W   = 4;
    localparam logic [3:0]  ID_IDLE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Round-robin pick: search starts just after the last owner and wraps,
    // so the last owner itself has the lowest priority. Caller guarantees
    // at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                           input logic [1:0]         last);
        logic [1:0] pick;
        int         idx;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req_v[idx]) begin
                pick = 2'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Bit-period tick generator: a down-counter that pulses tick for one cycle
// when it reaches zero and then reloads TICK_DIV-1, so every tick period is
// exactly TICK_DIV cycles. reload restarts the period from the top.
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic reload,
    output logic tick
);

    localparam int                CNT_W      = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  RELOAD_VAL = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    // Next count: reload on request or at the end of a period, else count down.
    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        if (reload || tick) begin
            cnt_d = RELOAD_VAL;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Round-robin pattern scheduler: grants one of three requesters, captures its
// 12-bit pattern and shifts it out MSB first, one bit per TICK_DIV cycles,
// followed by a one-bit-period quiet gap and a done pulse.
// Optional feature macro PATTERN_REPEAT_EN: when defined, each grant sends the
// captured pattern REPEATS times back-to-back before the gap; when undefined,
// each grant sends the pattern once.
module pattern_scheduler
    import pattern_sched_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int REPEATS  = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PAT_W-1:0] pat,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     serial_out,
    output logic                     done,
    output logic [3:0]               active_id
);

`ifdef PATTERN_REPEAT_EN
    localparam int SENDS = REPEATS;
`else
    localparam int SENDS = 1;
`endif
    // Send counter is sized for the repeat count so both builds share it.
    localparam int         SEND_W     = $clog2(REPEATS + 1);
    localparam logic [1:0] OWNER_RST  = 2'(NUM_REQ - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    state_e               state_q,  state_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;
    logic [1:0]           owner_q,  owner_d;
    logic [PAT_W-1:0]     shreg_q,  shreg_d;
    logic [PAT_W-1:0]     backup_q, backup_d;
    logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [SEND_W-1:0]    send_q,   send_d;
    logic                 done_q,   done_d;
    logic                 tick;
    logic                 reload;

    logic [PAT_W-1:0]     pat_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pat_slice
            assign pat_slice[gi] = pat[gi*PAT_W +: PAT_W];
        end
    endgenerate

    // The bit period restarts in LOAD so the first bit gets a full period.
    assign reload = (state_q == ST_LOAD);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .reload  (reload),
        .tick    (tick)
    );

    // Next-state logic: arbitration in IDLE, capture in LOAD, bit shifting
    // and repeat handling in SHIFT, one quiet bit period in GAP.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        shreg_d  = shreg_q;
        backup_d = backup_q;
        bitcnt_d = bitcnt_q;
        send_d   = send_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = rr_pick(req, owner_q);
                    grant_d = NUM_REQ'(1) << owner_d;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d  = pat_slice[owner_q];
                backup_d = pat_slice[owner_q];
                bitcnt_d = '0;
                send_d   = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (bitcnt_q == LAST_BIT) begin
                        if (send_q == SEND_W'(SENDS - 1)) begin
                            state_d = ST_GAP;
                        end else begin
                            send_d   = send_q + SEND_W'(1);
                            shreg_d  = backup_q;
                            bitcnt_d = '0;
                        end
                    end else begin
                        shreg_d  = {shreg_q[PAT_W-2:0], 1'b0};
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    grant_d = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any send and makes requester 0 first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= OWNER_RST;
            shreg_q  <= '0;
            backup_q <= '0;
            bitcnt_q <= '0;
            send_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            shreg_q  <= shreg_d;
            backup_q <= backup_d;
            bitcnt_q <= bitcnt_d;
            send_q   <= send_d;
            done_q   <= done_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign serial_out = (state_q == ST_SHIFT) && shreg_q[PAT_W-1];
    assign done       = done_q;
    assign active_id  = (state_q == ST_IDLE) ? ID_IDLE : {2'b00, owner_q};

endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler (TICK_DIV=2, REPEATS=2). Stimulus
// pushes the expected grant/pattern per send; a negedge monitor captures
// each send's serial waveform and compares when done pulses.
module tb_pattern_scheduler;

    localparam int TD  = 2;
    localparam int REP = 2;
`ifdef PATTERN_REPEAT_EN
    localparam int SENDS = REP;
`else
    localparam int SENDS = 1;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req     = '0;
    logic [35:0] pat     = '0;
    logic [2:0]  grant;
    logic        busy;
    logic        serial_out;
    logic        done;
    logic [3:0]  active_id;

    pattern_scheduler #(
        .TICK_DIV (TD),
        .REPEATS  (REP)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .pat        (pat),
        .grant      (grant),
        .busy       (busy),
        .serial_out (serial_out),
        .done       (done),
        .active_id  (active_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  g;
        logic [3:0]  id;
        logic [11:0] p;
        int          idle_before;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Expected per-cycle serial_out over the busy window: LOAD cycle, each
    // bit held TD cycles (SENDS times), then TD cycles of gap.
    function automatic logic [127:0] build_wave(input logic [11:0] p, output int len);
        logic [127:0] w;
        w   = '0;
        len = 1;
        for (int s = 0; s < SENDS; s++) begin
            for (int b = 11; b >= 0; b--) begin
                for (int t = 0; t < TD; t++) begin
                    w = {w[126:0], p[b]};
                    len++;
                end
            end
        end
        for (int t = 0; t < TD; t++) begin
            w = {w[126:0], 1'b0};
            len++;
        end
        return w;
    endfunction

    function automatic exp_t mk(input logic [2:0] g, input logic [3:0] id,
                                input logic [11:0] p, input int idle_before);
        exp_t e;
        e.g = g; e.id = id; e.p = p; e.idle_before = idle_before;
        return e;
    endfunction

    // Monitor state
    logic         in_txn = 1'b0;
    exp_t         cur;
    logic [127:0] wave;
    int           nbits;
    int           idle_cnt = 0;
    int           txn_idle;
    logic         grant_held;
    logic         id_held;

    always @(negedge clock) begin
        if (!reset_n) begin
            if (in_txn && sb.size() > 0) begin
                cur = sb.pop_front();
            end
            in_txn   = 1'b0;
            idle_cnt = 0;
        end else if (busy) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                if (sb.size() > 0) begin
                    cur = sb[0];
                end else begin
                    cur = mk(3'b000, 4'hF, 12'h000, -1);
                end
                txn_idle   = idle_cnt;
                wave       = '0;
                nbits      = 0;
                grant_held = 1'b1;
                id_held    = 1'b1;
            end
            wave = {wave[126:0], serial_out};
            nbits++;
            if (grant !== cur.g) grant_held = 1'b0;
            if (active_id !== cur.id) id_held = 1'b0;
        end else if (done) begin
            if (!in_txn) begin
                check("done_without_send", done, 1'b0);
            end else begin
                logic [127:0] ew;
                int           elen;
                ew = build_wave(cur.p, elen);
                check("grant_held", grant_held, 1'b1);
                check("active_id_held", id_held, 1'b1);
                check("busy_cycles", nbits, elen);
                check("serial_wave", wave, ew);
                check("active_id_at_done", active_id, 4'hF);
                check("grant_at_done", grant, 3'b000);
                if (cur.idle_before >= 0) begin
                    check("idle_before_grant", txn_idle, cur.idle_before);
                end
                $display("txn grant=%b id=%0d pat=%03h busy_cycles=%0d", cur.g, cur.id, cur.p, nbits);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                end
                in_txn = 1'b0;
            end
            idle_cnt = 1;
        end else begin
            idle_cnt++;
        end
    end

    task automatic pulse_req(input logic [2:0] bits);
        @(negedge clock);
        req = bits;
        @(posedge clock);
        #1;
        req = '0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy || done) && t < 600) begin
            @(negedge clock);
            #1;
            t++;
        end
        check({name, "_pending"}, sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},      grant,      3'b000);
        check({tag, "_busy"},       busy,       1'b0);
        check({tag, "_serial"},     serial_out, 1'b0);
        check({tag, "_done"},       done,       1'b0);
        check({tag, "_active_id"},  active_id,  4'hF);
    endtask

    initial begin
        int         seen;
        logic [2:0] prev_g;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");

        // Round robin with all three requesting; requester 2 has an all-zero pattern.
        pat = {12'h000, 12'h0F0, 12'h3C1};
        sb.push_back(mk(3'b001, 4'd0, 12'h3C1, -1));
        sb.push_back(mk(3'b010, 4'd1, 12'h0F0, 1));
        sb.push_back(mk(3'b100, 4'd2, 12'h000, 1));
        sb.push_back(mk(3'b001, 4'd0, 12'h3C1, 1));
        reset_n = 1'b1;
        req     = 3'b111;
        seen    = 0;
        prev_g  = '0;
        for (int c = 0; c < 400 && seen < 4; c++) begin
            @(posedge clock);
            #1;
            if (grant != 3'b000 && prev_g == 3'b000) seen++;
            prev_g = grant;
        end
        req = '0;
        drain("rr_all");

        // Single send of A5F, MSB first.
        pat[11:0] = 12'b1010_0101_1111;
        sb.push_back(mk(3'b001, 4'd0, 12'b1010_0101_1111, -1));
        pulse_req(3'b001);
        drain("a5f");

        // Pattern changed after LOAD must not affect the send.
        pat[23:12] = 12'h6C3;
        sb.push_back(mk(3'b010, 4'd1, 12'h6C3, -1));
        pulse_req(3'b010);
        @(posedge clock);
        #1;
        pat[23:12] = 12'h924;
        drain("pat_change");

        // Reset in the middle of bit 5 abandons the send immediately.
        pat[11:0] = 12'hFFF;
        sb.push_back(mk(3'b001, 4'd0, 12'hFFF, -1));
        pulse_req(3'b001);
        repeat (11) @(posedge clock);
        #3;
        check("bit5_serial", serial_out, 1'b1);
        check("bit5_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clock);
        @(negedge clock);
        pat[35:24] = 12'hC35;
        sb.push_back(mk(3'b100, 4'd2, 12'hC35, -1));
        reset_n = 1'b1;
        req     = 3'b100;
        @(posedge clock);
        #1;
        check("grant_after_reset", grant, 3'b100);
        req = '0;
        drain("after_reset");

        // Last owner 2: requester 0 wins over 1.
        pat[11:0]  = 12'h00F;
        pat[23:12] = 12'hF00;
        sb.push_back(mk(3'b001, 4'd0, 12'h00F, -1));
        pulse_req(3'b011);
        drain("rr_01");

        // Last owner 0: requester 2 wins, skipping idle requester 1.
        pat[35:24] = 12'h5A5;
        sb.push_back(mk(3'b100, 4'd2, 12'h5A5, -1));
        pulse_req(3'b101);
        drain("rr_skip");

        // 801 pattern (sent REPEATS times when the repeat feature is built in).
        pat[11:0] = 12'h801;
        sb.push_back(mk(3'b001, 4'd0, 12'h801, -1));
        pulse_req(3'b001);
        drain("p801");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25_000_000: clock cycles per output bit (≥2).
REQ-002 SHALL have parameter REPEATS, default 2: sends per grant when PATTERN_REPEAT_EN is defined (≥1).
REQ-003 SHALL have port clock, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 3: level request per requester (bit i = requester i).
REQ-006 SHALL have port pat, input, 36: requester i pattern on pat[12*i+11:12*i], MSB sent first.
REQ-007 SHALL have port grant, output, 3: one-hot owner, held from LOAD through GAP.
REQ-008 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-009 SHALL have port serial_out, output, 1: current pattern bit; 0 outside SHIFT.
REQ-010 SHALL have port done, output, 1: one-cycle pulse on GAP→IDLE.
REQ-011 SHALL have port active_id, output, 4: owner index 0..2 for hex decoder; 4'hF when idle.

Function
REQ-012 SHALL implement FSM IDLE→LOAD→SHIFT→GAP→IDLE.
- IDLE: any req bit high → LOAD next edge; grant registered at this edge.
- LOAD: one cycle; captures owner pattern into 12-bit shift register and backup copy; reloads tick counter to TICK_DIV-1; bit counter=0.
- SHIFT: serial_out=shreg[11]; on tick, shift left one, bit counter+1; tick with bit counter==11 ends the send.
- GAP: serial_out=0 for exactly TICK_DIV cycles, then IDLE with done=1.
REQ-013 SHALL assert tick one cycle when the down-counter reaches 0, then reload TICK_DIV-1; each bit is held exactly TICK_DIV cycles.
REQ-014 SHALL arbitrate round-robin: search starts at index (last owner+1) mod 3; after reset last owner=2 (requester 0 first).
REQ-015 SHALL ignore req and pat changes after LOAD; a send is never aborted by deasserted req.
REQ-016 SHALL make grant-to-serial latency 2 cycles: req high in IDLE at edge N → grant at N+1, first bit at N+2.
REQ-017 SHALL grant a new request in the cycle after done when requests are still pending (no extra idle cycles).
REQ-018 SHALL give an all-zero pattern full timing (12 bit periods plus GAP).

Reset
REQ-019 SHALL force on reset_n low, without waiting for clock: state=IDLE, grant=0, busy=0, serial_out=0, done=0, active_id=4'hF, counters=0, shift register=0, last owner=2.
REQ-020 SHALL abandon any send on reset mid-operation; first grant after release follows REQ-014.

Configuration
REQ-021 SHALL use macro PATTERN_REPEAT_EN: when defined, the end of send reloads the shift register from the backup and repeats until REPEATS sends, then GAP; when undefined, exactly one send per grant and REPEATS is unused.

Structure
REQ-022 SHALL put state enum, NUM_REQ=3, PAT_W=12 and ID_IDLE=4'hF in shared package pattern_sched_pkg.
REQ-023 SHALL implement the tick down-counter as sub-module tick_gen (inputs clock, reset_n, reload; output tick).

Verification (TICK_DIV=2, REPEATS=2)
REQ-024 SHALL cover: req=001, pat[11:0]=12'hA5F → serial_out 101001011111 with each bit 2 cycles, then 2 cycles 0, then done pulse, active_id 0→F.
REQ-025 SHALL cover: req=111 held → grants 001,010,100,001 in order with no idle cycle between done and next grant.
REQ-026 SHALL cover: req=010 pulsed one cycle with pat changed after LOAD → full original pattern sent, grant=010 until done.
REQ-027 SHALL cover: reset_n low at bit 5 → outputs at reset values immediately; after release req=100 granted within 1 cycle.
REQ-028 SHALL cover: PATTERN_REPEAT_EN defined, pat=12'h801 → 100000000001 sent twice back-to-back (48 cycles), then GAP, one done.
